qspi_regfile_target: RTL
========================

// Module: qspi_regfile_target
// PURPOSE
//   QSPI target that sits directly downstream of the UART-to-QSPI bridge and consumes its
//   qspi_csb/qspi_sck/qspi_io_out stream. It oversamples on the system clock and assembles
//   nibbles into bytes, high nibble first. The first byte is a command; the following bytes
//   read and optionally write a 16x8 register file.
//   A response nibble is driven back on tgt_io_out, which feeds the bridge's qspi_io_in.
// PARAMETERS
//   SYNC_STAGES  2      flops in each input synchroniser (csb, sck, io[3:0]); legal values 2..3
//   ID_BYTE      8'hA5  response byte returned during the command byte
// PORTS
//   clk           in   1  system clock
//   reset         in   1  synchronous reset, active-high
//   qspi_csb      in   1  chip select from bridge, active-low, asynchronous to clk
//   qspi_sck      in   1  serial clock from bridge, asynchronous
//   qspi_io       in   4  nibble from bridge, asynchronous
//   tgt_io_out    out  4  response nibble to the bridge's qspi_io_in
//   tgt_io_oe     out  1  response drive enable
//   reg_rd_addr   in   4  side-port read address, used by the rest of the design
//   reg_rd_data   out  8  reg[reg_rd_addr], combinational read
//   wr_strobe     out  1  one-cycle pulse when a register is written
//   wr_addr       out  4  address of that write; valid while wr_strobe is high
//   busy          out  1  high while the synchronised csb is low
// BEHAVIOUR
// - Reset (sync, high): every output 0; all 16 registers 0x00; FSM in IDLE; pointer 0; nibble phase 0.
// - Synchronisation: each input passes through SYNC_STAGES flops. Edge detection compares the
//   last synchronised stage with its registered copy.
//   * rise/fall = sck edges seen at clk granularity
//   * Latency from pin to action is SYNC_STAGES+1 clks.
// - FSM states: IDLE, CMD, DATA.
// - IDLE
//   * On csb falling: go to CMD; busy=1, tgt_io_oe=1, tgt_io_out=ID_BYTE[7:4], phase=0.
// - Nibble capture (CMD or DATA), on sck rise:
//   * phase 0: hi <= io; phase <= 1.
//   * phase 1: byte = {hi, io}; phase <= 0; byte_done pulses for 1 clk.
// - Response update (CMD or DATA), on sck fall (the bridge has already sampled):
//   * If phase==1 (the high nibble was just taken): tgt_io_out = low nibble of the current response byte.
//   * If phase==0 (a byte just completed): tgt_io_out = high nibble of the next response byte.
//   * Response for the command byte = ID_BYTE.
//   * Response for each data byte = reg[ptr], read at the sck fall that starts that byte.
// - CMD, on byte_done:
//   * wen <= byte[7]; ptr <= byte[3:0]; bits 6:4 are ignored; go to DATA.
//   * No register is written by the command byte.
// - DATA, on byte_done:
//   * If wen: reg[ptr] <= byte; wr_strobe=1 and wr_addr=ptr for 1 clk.
//   * ptr <= ptr+1 in all cases, wrapping 4'hF -> 4'h0.
//   * The read-before-write value of reg[ptr] is the byte already shifted out.
//   * Unlimited bytes per frame.
// - Frame end, on csb rising (any state):
//   * Go to IDLE; busy=0; tgt_io_oe=0; tgt_io_out=0.
//   * A partial byte (phase==1) is discarded with no write.
//   * A csb rise and sck edge in the same clk: the csb rise wins and the edge is ignored.
// - sck edges while csb is high are ignored.
// - A csb fall in CMD/DATA cannot occur without an intervening rise.
// - Side read port is independent of the FSM.
//   * On a write to the same address in the same clk, reg_rd_data shows the old value.
//   * The new value is visible from the next clk.
// - reset asserted mid-frame: immediate return to the reset state above, including clearing the registers.
//   * The frame in progress is abandoned; the next csb fall starts a fresh CMD.
// TESTING
//   1. Frame 0x83,0x11,0x22 (csb low, sck half-period 521 clk).
//      -> Response bytes 0xA5,0x00,0x00.
//      -> reg3=0x11, reg4=0x22.
//      -> Two wr_strobe pulses, wr_addr 3 then 4.
//   2. After test 1, frame 0x03,0xFF,0xFF.
//      -> Response 0xA5,0x11,0x22.
//      -> No wr_strobe; reg3/reg4 unchanged.
//   3. Frame 0x8F,0xAA,0xBB.
//      -> reg15=0xAA, reg0=0xBB (pointer wraps).
//      -> reg_rd_addr=0 reads 0xBB one clk after the strobe.
//   4. Frame 0x80, then the high nibble 0xC only, then csb rises.
//      -> No write; reg0 unchanged; tgt_io_oe=0 and busy=0 within SYNC_STAGES+2 clks.
//   5. Assert reset during the DATA byte of frame 0x85,0x5A.
//      -> All outputs 0; reg5=0x00.
//      -> A following frame 0x05,0x00 returns 0xA5,0x00.
//   6. sck pulses with csb high.
//      -> busy stays 0; no strobe; register contents unchanged.

Source files
------------

// File: rtl/qspi_regfile_target.sv
// QSPI target: oversamples csb/sck/io on clk, assembles command and data bytes,
// and serves a 16x8 register file with an ID/readback response on tgt_io_out.
module qspi_regfile_target #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  ID_BYTE     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       qspi_csb,
    input  logic       qspi_sck,
    input  logic [3:0] qspi_io,
    output logic [3:0] tgt_io_out,
    output logic       tgt_io_oe,
    input  logic [3:0] reg_rd_addr,
    output logic [7:0] reg_rd_data,
    output logic       wr_strobe,
    output logic [3:0] wr_addr,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0]      csb_sync_q, csb_sync_d;
    logic [SYNC_STAGES-1:0]      sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0][3:0] io_sync_q, io_sync_d;
    logic                        csb_prev_q, csb_prev_d;
    logic                        sck_prev_q, sck_prev_d;

    state_t     state_q, state_d;
    logic       phase_q, phase_d;
    logic [3:0] hi_q, hi_d;
    logic       wen_q, wen_d;
    logic [3:0] ptr_q, ptr_d;
    logic [7:0] resp_q, resp_d;
    logic [3:0] out_q, out_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic [7:0] regs_q [16];
    logic [7:0] regs_d [16];

    logic       csb_s, sck_s;
    logic [3:0] io_s;
    logic       csb_fall, csb_rise, sck_rise, sck_fall;
    logic       byte_done;
    logic [7:0] cur_byte;
    logic [7:0] ptr_byte;

    assign csb_s    = csb_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign io_s     = io_sync_q[SYNC_STAGES-1];
    assign csb_fall = csb_prev_q & ~csb_s;
    assign csb_rise = ~csb_prev_q & csb_s;
    assign sck_rise = ~sck_prev_q & sck_s;
    assign sck_fall = sck_prev_q & ~sck_s;
    assign cur_byte = {hi_q, io_s};
    assign ptr_byte = regs_q[ptr_q];

    always_comb begin
        csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], qspi_csb};
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], qspi_sck};
        io_sync_d   = {io_sync_q[SYNC_STAGES-2:0], qspi_io};
        csb_prev_d  = csb_s;
        sck_prev_d  = sck_s;
        state_d     = state_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        wen_d       = wen_q;
        ptr_d       = ptr_q;
        resp_d      = resp_q;
        out_d       = out_q;
        oe_d        = oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = 4'h0;
        regs_d      = regs_q;
        byte_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (csb_fall) begin
                    state_d = CMD;
                    busy_d  = 1'b1;
                    oe_d    = 1'b1;
                    out_d   = ID_BYTE[7:4];
                    resp_d  = ID_BYTE;
                    phase_d = 1'b0;
                end
            end
            CMD, DATA: begin
                // Frame end takes priority over any sck edge seen in the same clk.
                if (csb_rise) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    oe_d    = 1'b0;
                    out_d   = 4'h0;
                    phase_d = 1'b0;
                end else if (sck_rise) begin
                    if (!phase_q) begin
                        hi_d    = io_s;
                        phase_d = 1'b1;
                    end else begin
                        phase_d   = 1'b0;
                        byte_done = 1'b1;
                    end
                    if (byte_done) begin
                        if (state_q == CMD) begin
                            wen_d   = cur_byte[7];
                            ptr_d   = cur_byte[3:0];
                            state_d = DATA;
                        end else begin
                            if (wen_q) begin
                                regs_d[ptr_q] = cur_byte;
                                wr_strobe_d   = 1'b1;
                                wr_addr_d     = ptr_q;
                            end
                            ptr_d = ptr_q + 4'h1;
                        end
                    end
                end else if (sck_fall) begin
                    // The fall after a completed byte fetches the next readback byte.
                    if (phase_q) begin
                        out_d = resp_q[3:0];
                    end else begin
                        resp_d = ptr_byte;
                        out_d  = ptr_byte[7:4];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csb_sync_q  <= '1;
            sck_sync_q  <= '0;
            io_sync_q   <= '0;
            csb_prev_q  <= 1'b1;
            sck_prev_q  <= 1'b0;
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            hi_q        <= 4'h0;
            wen_q       <= 1'b0;
            ptr_q       <= 4'h0;
            resp_q      <= 8'h00;
            out_q       <= 4'h0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 4'h0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            csb_sync_q  <= csb_sync_d;
            sck_sync_q  <= sck_sync_d;
            io_sync_q   <= io_sync_d;
            csb_prev_q  <= csb_prev_d;
            sck_prev_q  <= sck_prev_d;
            state_q     <= state_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            wen_q       <= wen_d;
            ptr_q       <= ptr_d;
            resp_q      <= resp_d;
            out_q       <= out_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            regs_q      <= regs_d;
        end
    end

    assign tgt_io_out  = out_q;
    assign tgt_io_oe   = oe_q;
    assign busy        = busy_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign reg_rd_data = regs_q[reg_rd_addr];

endmodule
